fpaddsub_align_shift_pipe: RTL and testbench
============================================

FPADDSUB_ALIGN_SHIFT_PIPE -- requirements
Module: fpaddsub_align_shift_pipe

Interface
- REQ-001 SHALL have no parameters; all widths are fixed as listed.
- REQ-002 clk  input  1  single clock; all state updates on rising edge.
- REQ-003 rst  input  1  reset, asynchronous, active-high.
- REQ-004 flush  input  1  synchronous clear of all in-flight entries.
- REQ-005 in_valid  input  1  m_in/shift_in valid this cycle.
- REQ-006 in_ready  output  1  block accepts input this cycle.
- REQ-007 m_in  input  24  smaller mantissa, hidden bit at [23].
- REQ-008 shift_in  input  8  exponent difference (unsigned right-shift amount).
- REQ-009 out_valid  output  1  m_out/sticky_out valid.
- REQ-010 out_ready  input  1  downstream accepts output this cycle.
- REQ-011 m_out  output  26  aligned mantissa {mantissa, guard, round}.
- REQ-012 sticky_out  output  1  OR of all bits shifted out below m_out[0].

Function
- REQ-013 Operand SHALL be X = {m_in, 2'b00} (26 bits); result m_out = X >> shift_in (logical, zero fill).
- REQ-014 shift_in >= 26 SHALL saturate: m_out = 0, sticky_out = |m_in.
- REQ-015 Stage 1 (S1) SHALL register a coarse right shift by 4*shift_in[4:2] (0..28), partial sticky, shift_in[1:0], and the saturate flag.
- REQ-016 Stage 2 (S2) SHALL register a fine right shift by shift_in[1:0] (0..3) of the S1 value; sticky = S1 sticky OR fine-shifted-out bits.
- REQ-017 Latency SHALL be exactly 2 cycles from accepted input to out_valid when out_ready stays 1.
- REQ-018 Throughput SHALL be one result per cycle with out_ready held 1.
- REQ-019 Transfer occurs on valid & ready on the same edge; in_valid=0 cycles create bubbles, no result produced.
- REQ-020 Each stage advances when it is empty or the next stage advances; S2 advances on out_ready or when empty.
- REQ-021 in_ready SHALL be 1 when S1 is empty or S1 advances this cycle (combinational from out_ready allowed).
- REQ-022 While out_valid=1 and out_ready=0, m_out/sticky_out SHALL hold stable.
- REQ-023 With both stages full and out_ready=0, in_ready SHALL be 0; no entry lost or duplicated.
- REQ-024 flush=1 SHALL clear both stage valids on the next edge; input offered that cycle is dropped; flush wins over simultaneous accept.
- REQ-025 Results SHALL leave in acceptance order.

Reset
- REQ-026 rst=1 SHALL immediately clear S1/S2 valid: out_valid=0, m_out=0, sticky_out=0, in_ready=1 after release.
- REQ-027 Reset mid-operation SHALL discard all in-flight entries; first post-reset output derives only from post-reset inputs.

Configuration
- REQ-028 Macro FPADDSUB_ALIGN_STICKY_EN defined: sticky logic per REQ-012/014/016.
- REQ-029 Macro undefined: sticky_out tied 0, no sticky registers; m_out, latency, handshake unchanged.

Verification
- REQ-030 m_in=24'h800000, shift_in=1, out_ready=1 -> 2 cycles later m_out=26'h1000000, sticky_out=0.
- REQ-031 m_in=24'hC00001, shift_in=3 -> m_out=26'h0600000, sticky_out=1 (0 with macro undefined).
- REQ-032 m_in=24'h800000: shift_in=25 -> m_out=26'h0000001, sticky 0; shift_in=26 and shift_in=200 -> m_out=0, sticky 1.
- REQ-033 Back-to-back 5 inputs, out_ready=0 for cycles 2-6 -> in_ready=0 once 2 held, all 5 results in order, none lost.
- REQ-034 Assert rst with 2 entries in flight -> out_valid=0 immediately, no stale output after release; same check for flush=1 with in_valid=1.

Source files
------------

// File: rtl/fpaddsub_align_shift_pipe.sv
// Two-stage mantissa alignment shifter for FP add/sub: coarse (multiple-of-4) shift, then fine (0..3) shift.
// Optional sticky tracking is enabled by defining FPADDSUB_ALIGN_STICKY_EN; otherwise sticky_out is tied 0.
module fpaddsub_align_shift_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] m_in,
    input  logic [7:0]  shift_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [25:0] m_out,
    output logic        sticky_out
);

    // Handshake: a beat transfers on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and a stage loads only when it is empty or drains.
    logic        s1_valid;
    logic [25:0] s1_m;
    logic [1:0]  s1_fine;
    logic        s1_sat;
    logic        s2_valid;
    logic [25:0] s2_m;
    logic        s1_adv;
    logic        s2_adv;

    logic [25:0] x;
    logic [4:0]  coarse_amt;
    logic        sat;
    logic [53:0] coarse_wide;
    logic [28:0] fine_wide;
    logic [25:0] s2_m_next;

    assign x           = {m_in, 2'b00};
    assign coarse_amt  = {shift_in[4:2], 2'b00};
    assign sat         = (shift_in >= 8'd26);
    // Extra low bits catch whatever falls off the bottom so sticky is a simple OR.
    assign coarse_wide = {x, 28'b0} >> coarse_amt;
    assign fine_wide   = {s1_m, 3'b000} >> s1_fine;
    assign s2_m_next   = s1_sat ? 26'd0 : fine_wide[28:3];

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;
    assign m_out     = s2_m;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_m     <= 26'd0;
            s1_fine  <= 2'd0;
            s1_sat   <= 1'b0;
            s2_valid <= 1'b0;
            s2_m     <= 26'd0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (s1_adv) s1_valid <= in_valid;
                if (s2_adv) s2_valid <= s1_valid;
            end
            if (s1_adv && in_valid) begin
                s1_m    <= coarse_wide[53:28];
                s1_fine <= shift_in[1:0];
                s1_sat  <= sat;
            end
            if (s2_adv && s1_valid) begin
                s2_m <= s2_m_next;
            end
        end
    end

`ifdef FPADDSUB_ALIGN_STICKY_EN
    logic s1_sticky;
    logic s2_sticky;
    logic s1_sticky_next;
    logic s2_sticky_next;

    // Saturated operands lose every bit, so sticky is just "any mantissa bit set".
    assign s1_sticky_next = sat ? (|m_in) : (|coarse_wide[27:0]);
    assign s2_sticky_next = s1_sticky | (!s1_sat && (|fine_wide[2:0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sticky <= 1'b0;
            s2_sticky <= 1'b0;
        end else begin
            if (s1_adv && in_valid) s1_sticky <= s1_sticky_next;
            if (s2_adv && s1_valid) s2_sticky <= s2_sticky_next;
        end
    end

    assign sticky_out = s2_sticky;
`else
    assign sticky_out = 1'b0;
`endif

endmodule

// File: tb/tb_fpaddsub_align_shift_pipe.sv
// Directed bench for fpaddsub_align_shift_pipe: latency, saturation, backpressure, reset and flush.
// Expected sticky values are masked to 0 unless FPADDSUB_ALIGN_STICKY_EN is defined.
module tb_fpaddsub_align_shift_pipe;

`ifdef FPADDSUB_ALIGN_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] m_in;
    logic [7:0]  shift_in;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] m_out;
    logic        sticky_out;

    int n_cmp;
    int n_fail;
    logic [26:0] exp_q[$];

    // Hand-computed directed vectors: X = {m,2'b00}, result = X >> shift
    logic [23:0] vm  [0:10] = '{24'h800000, 24'hC00001, 24'h800000, 24'h800000, 24'h800000,
                                24'hFFFFFF, 24'h000001, 24'h000001, 24'hABCDEF, 24'h800000,
                                24'h000001};
    logic [7:0]  vsh [0:10] = '{8'd1, 8'd3, 8'd25, 8'd26, 8'd200, 8'd0, 8'd2, 8'd3, 8'd13, 8'd24, 8'd28};
    logic [25:0] vem [0:10] = '{26'h1000000, 26'h0600000, 26'h0000001, 26'h0000000, 26'h0000000,
                                26'h3FFFFFC, 26'h0000001, 26'h0000000, 26'h0001579, 26'h0000002,
                                26'h0000000};
    logic        ves [0:10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    fpaddsub_align_shift_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .m_in       (m_in),
        .shift_in   (shift_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .m_out      (m_out),
        .sticky_out (sticky_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        m_in = 24'd0; shift_in = 8'd0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || m_out !== 26'd0 || sticky_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b m=%h s=%b, want v=0 m=0 s=0", out_valid, m_out, sticky_out);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_single(input int idx);
        logic es;
        es = ves[idx] & STICKY_EN;
        @(negedge clk);
        m_in = vm[idx]; shift_in = vsh[idx]; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early[%0d]: out_valid got %b after 1 cycle, want 0", idx, out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || m_out !== vem[idx] || sticky_out !== es) begin
            n_fail++;
            $display("FAIL single[%0d] m=%h sh=%0d: got v=%b m=%h s=%b, want v=1 m=%h s=%b",
                     idx, vm[idx], vsh[idx], out_valid, m_out, sticky_out, vem[idx], es);
        end
    endtask

    task automatic test_back_to_back();
        int sent;
        int got;
        int cyc;
        logic        hold_chk;
        logic [25:0] held_m;
        logic        held_s;
        logic [26:0] e;
        sent = 0; got = 0; cyc = 0; hold_chk = 1'b0; held_m = '0; held_s = 1'b0;
        exp_q.delete();
        while (got < 5 && cyc < 40) begin
            @(negedge clk);
            if (hold_chk) begin
                n_cmp++;
                if (m_out !== held_m || sticky_out !== held_s) begin
                    n_fail++;
                    $display("FAIL b2b_hold cyc %0d: got m=%h s=%b, want m=%h s=%b", cyc, m_out, sticky_out, held_m, held_s);
                end
            end
            in_valid = (sent < 5);
            if (sent < 5) begin
                m_in = vm[sent + 1]; shift_in = vsh[sent + 1];
            end
            out_ready = !(cyc >= 2 && cyc <= 6);
            #1;
            if (cyc >= 2 && cyc <= 6) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready cyc %0d: got %b, want 0", cyc, in_ready);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({vem[sent + 1], ves[sent + 1] & STICKY_EN});
                sent++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra cyc %0d: got unexpected m=%h, want no output", cyc, m_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_out, sticky_out} !== e) begin
                        n_fail++;
                        $display("FAIL b2b_data #%0d: got m=%h s=%b, want m=%h s=%b", got, m_out, sticky_out, e[26:1], e[0]);
                    end
                end
                got++;
            end
            hold_chk = out_valid && !out_ready;
            held_m = m_out;
            held_s = sticky_out;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (got !== 5 || sent !== 5) begin
            n_fail++;
            $display("FAIL b2b_count: got sent=%0d received=%0d, want 5/5", sent, got);
        end
    endtask

    task automatic load_two();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; m_in = vm[0]; shift_in = vsh[0];
        @(negedge clk);
        m_in = vm[1]; shift_in = vsh[1];
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL load_two: out_valid got %b, want 1", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        load_two();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || m_out !== 26'd0 || sticky_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b m=%h s=%b, want v=0 m=0 s=0", out_valid, m_out, sticky_out);
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_stale cyc %0d: out_valid got %b, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_flush();
        load_two();
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; m_in = vm[5]; shift_in = vsh[5];
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clear: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_stale cyc %0d: out_valid got %b, want 0", i, out_valid);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        for (int i = 0; i < 11; i++) test_single(i);
        test_back_to_back();
        test_reset_mid();
        test_single(1);
        test_flush();
        test_single(8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
